// File: rtl/keypad_scanner.sv
// Purpose : scans a 4x4 active-low matrix keypad, debounces whole frames, emits hex key codes.
// Latency : accept/release registered one cycle after the frame-evaluating tick (DEBOUNCE frames).
// Backpr. : none; keyValid is a one-cycle pulse and entry/keyCode hold until the next accept.
//
// Ports:
//   clock5   - 5 MHz system clock (only clock)
//   reset    - synchronous active-high reset
//   row      - keypad row lines, active-low, asynchronous to clock5
//   col      - column drive, active-low, exactly one bit low
//   keyCode  - code (4*rowIdx + colIdx) of the last accepted key
//   keyValid - one-cycle pulse per accepted press
//   keyDown  - high while the accepted key is considered held
//   entry    - last four accepted codes, newest in [3:0]
module keypad_scanner #(
  parameter int SCAN_DIV = 624,
  parameter int DEBOUNCE = 4
) (
  input  logic        clock5,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  keyCode,
  output logic        keyValid,
  output logic        keyDown,
  output logic [15:0] entry
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESS_CHK = 2'd1;
  localparam logic [1:0] HELD      = 2'd2;
  localparam logic [1:0] REL_CHK   = 2'd3;

  localparam logic [9:0] DIV_LAST = 10'(SCAN_DIV);
  localparam logic [3:0] DEB_CNT  = 4'(DEBOUNCE);

  logic [9:0]  prescaler;
  logic        tick;
  logic [1:0]  colIdx;
  logic [3:0]  row_meta;
  logic [3:0]  row_sync;
  logic [15:0] hits;
  logic [15:0] col_hits;
  logic [15:0] frame_bits;
  logic        eval;
  logic        frame_none;
  logic        frame_single;
  logic [3:0]  frame_code;

  logic [1:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  cand, cand_nxt;
  logic        accept;

  assign tick = (prescaler == DIV_LAST);
  assign col  = ~(4'b0001 << colIdx);
  assign eval = tick && (colIdx == 2'd3);

  // Spread the four row hits of the current column onto their code positions
  // (bit 4*r + colIdx) so a frame is just the OR of its four column samples.
  assign col_hits = {3'b000, ~row_sync[3], 3'b000, ~row_sync[2],
                     3'b000, ~row_sync[1], 3'b000, ~row_sync[0]} << colIdx;

  assign frame_bits   = hits | col_hits;
  assign frame_none   = (frame_bits == 16'h0000);
  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  assign frame_single = !frame_none && ((frame_bits & (frame_bits - 16'd1)) == 16'h0000);

  always_comb begin
    frame_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (frame_bits[i]) frame_code = 4'(i);
    end
  end

  always_ff @(posedge clock5) begin
    if (reset) begin
      prescaler <= 10'd0;
      colIdx    <= 2'd0;
      row_meta  <= 4'b1111;
      row_sync  <= 4'b1111;
      hits      <= 16'h0000;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      if (tick) begin
        prescaler <= 10'd0;
        colIdx    <= colIdx + 2'd1;
        hits      <= eval ? 16'h0000 : frame_bits;
      end else begin
        prescaler <= prescaler + 10'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    accept    = 1'b0;
    if (eval) begin
      case (state)
        IDLE: begin
          if (frame_single) begin
            state_nxt = PRESS_CHK;
            cand_nxt  = frame_code;
            cnt_nxt   = 4'd1;
          end
        end
        PRESS_CHK: begin
          if (frame_single && (frame_code == cand)) begin
            if (cnt + 4'd1 == DEB_CNT) begin
              state_nxt = HELD;
              cnt_nxt   = 4'd0;
              accept    = 1'b1;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end
        end
        HELD: begin
          // Further keys while held are ignored: no rollover.
          if (frame_none) begin
            state_nxt = REL_CHK;
            cnt_nxt   = 4'd1;
          end
        end
        default: begin
          if (frame_none) begin
            if (cnt + 4'd1 == DEB_CNT) begin
              state_nxt = IDLE;
              cnt_nxt   = 4'd0;
            end else begin
              cnt_nxt = cnt + 4'd1;
            end
          end else begin
            state_nxt = HELD;
            cnt_nxt   = 4'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock5) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cand     <= 4'h0;
      keyValid <= 1'b0;
      keyDown  <= 1'b0;
      keyCode  <= 4'h0;
      entry    <= 16'h0000;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cand     <= cand_nxt;
      keyValid <= accept;
      keyDown  <= (state_nxt == HELD) || (state_nxt == REL_CHK);
      if (accept) begin
        keyCode <= cand;
        entry   <= {entry[11:0], cand};
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose : self-checking bench for keypad_scanner with a frame-level keypad reference model.
// Latency : stimulus changes only on frame boundaries; one frame is 16 clocks with SCAN_DIV=3.
// Backpr. : none; outputs are sampled on the falling edge.
module tb_keypad_scanner;

  localparam int SD = 3;
  localparam int DB = 4;
  localparam int FRAME = 4 * (SD + 1);

  logic        clock5 = 1'b0;
  logic        reset  = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyDown;
  logic [15:0] entry;
  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int errors = 0;

  // Reference model state: is a key accepted/held, length of the current
  // qualifying run of frames, key of that run, last accepted code and digits.
  bit          m_down;
  int          m_streak;
  logic [3:0]  m_key;
  logic [3:0]  m_code;
  logic [15:0] m_entry;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clock5  (clock5),
    .reset   (reset),
    .row     (row),
    .col     (col),
    .keyCode (keyCode),
    .keyValid(keyValid),
    .keyDown (keyDown),
    .entry   (entry)
  );

  always #5 clock5 = ~clock5;

  // Key at row r / column c shorts row[r] to col[c]: row r reads low while any
  // of its pressed keys sits on the column currently driven low.
  assign row = {~|(keys[15:12] & ~col), ~|(keys[11:8] & ~col),
                ~|(keys[7:4] & ~col),   ~|(keys[3:0] & ~col)};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_down   = 1'b0;
    m_streak = 0;
    m_key    = 4'h0;
    m_code   = 4'h0;
    m_entry  = 16'h0000;
  endtask

  // One frame with the given pressed-key set; reports whether it yields a press.
  task automatic model_frame(input logic [15:0] m, output bit pulse);
    int n;
    logic [3:0] k;
    n = $countones(m);
    k = 4'h0;
    for (int i = 0; i < 16; i++) if (m[i]) k = 4'(i);
    pulse = 1'b0;
    if (!m_down) begin
      if (m_streak == 0) begin
        if (n == 1) begin
          m_streak = 1;
          m_key    = k;
        end
      end else if (n == 1 && k == m_key) begin
        m_streak++;
        if (m_streak == DB) begin
          m_down   = 1'b1;
          m_streak = 0;
          m_code   = k;
          m_entry  = {m_entry[11:0], k};
          pulse    = 1'b1;
        end
      end else begin
        m_streak = 0;
      end
    end else begin
      if (m_streak == 0) begin
        if (n == 0) m_streak = 1;
      end else if (n == 0) begin
        m_streak++;
        if (m_streak == DB) begin
          m_down   = 1'b0;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
    end
  endtask

  // Runs one aligned frame. With rst_last, reset lands on the evaluating edge.
  task automatic frame(input logic [15:0] m, input bit rst_last);
    bit pulse;
    bit prev_down;
    int pulses;
    logic [3:0] ecol;
    keys      = m;
    prev_down = m_down;
    pulses    = 0;
    if (rst_last) begin
      model_reset();
      pulse = 1'b0;
    end else begin
      model_frame(m, pulse);
    end
    for (int i = 1; i <= FRAME; i++) begin
      if (rst_last && i == FRAME) reset = 1'b1;
      @(posedge clock5);
      @(negedge clock5);
      if (keyValid === 1'b1) pulses++;
      ecol = ~(4'b0001 << ((i / (SD + 1)) % 4));
      chk("col", col, ecol);
      chk("keyDown", keyDown, (i == FRAME) ? m_down : prev_down);
    end
    reset = 1'b0;
    chk("pulses", pulses, pulse);
    chk("keyCode", keyCode, m_code);
    chk("entry", entry, m_entry);
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) frame(m, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock5);
    @(negedge clock5);
    model_reset();
    chk("rst_col", col, 4'b1110);
    chk("rst_keyValid", keyValid, 1'b0);
    chk("rst_keyDown", keyDown, 1'b0);
    chk("rst_keyCode", keyCode, 4'h0);
    chk("rst_entry", entry, 16'h0000);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] cur;
    int sel;
    model_reset();
    repeat (3) @(posedge clock5);
    @(negedge clock5);
    do_reset();

    // Single press of code 6 (row1/col2), then release.
    frames(16'h0001 << 6, 6);
    chk("single_keyDown", keyDown, 1'b1);
    frames(16'h0000, 6);
    chk("single_entry", entry, 16'h0006);
    chk("single_code", keyCode, 4'h6);
    chk("single_released", keyDown, 1'b0);

    // Entry sequence 1..5.
    for (int k = 1; k <= 5; k++) begin
      frames(16'h0001 << k, 5);
      frames(16'h0000, 5);
    end
    chk("seq_entry", entry, 16'h2345);

    // Bounce on press: never reaches the debounce count.
    frames(16'h0001 << 7, 3);
    frames(16'h0000, 1);
    frames(16'h0001 << 7, 3);
    frames(16'h0000, 5);
    chk("bounce_code", keyCode, 4'h5);

    // Bounce on release of a held key.
    frames(16'h0001 << 8, 5);
    frames(16'h0000, 2);
    chk("relbounce_down", keyDown, 1'b1);
    frames(16'h0001 << 8, 3);
    frames(16'h0000, 5);
    chk("relbounce_entry", entry, 16'h3458);

    // Ghosting and rollover.
    frames(16'h0021, 6);
    frames(16'h0000, 2);
    frames(16'h0008, 5);
    frames(16'h0208, 3);
    frames(16'h0000, 5);
    chk("rollover_code", keyCode, 4'h3);
    chk("rollover_entry", entry, 16'h4583);

    // Reset mid-hold with key 10 still pressed.
    frames(16'h0001 << 10, 5);
    chk("midhold_down", keyDown, 1'b1);
    keys = 16'h0001 << 10;
    do_reset();
    frames(16'h0001 << 10, 5);
    chk("rehold_code", keyCode, 4'hA);
    chk("rehold_entry", entry, 16'h000A);
    frames(16'h0000, 5);

    // Reset on the accepting edge wins.
    frames(16'h0001 << 12, 3);
    frame(16'h0001 << 12, 1'b1);
    chk("rstwin_entry", entry, 16'h0000);
    frames(16'h0001 << 12, 5);
    frames(16'h0000, 5);

    // Randomized key activity with persistence between frames.
    cur = 16'h0000;
    for (int f = 0; f < 150; f++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 6 || sel == 7) cur = 16'h0000;
      else if (sel == 8) cur = 16'h0001 << $urandom_range(0, 15);
      else if (sel == 9) cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      frame(cur, $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
